control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired control sequencer for a 32-bit single-bus CPU.
// It steps through fetch (T0-T2) and up to five execute steps, and decodes every control line from the current step.
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        CONin,
  output logic        Rin,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLOout,
  output logic        HIout,
  output logic        LOout,
  output logic        INPORTout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Run,
  output logic [4:0]  Aluop
);

  typedef enum logic [3:0] {
    S_RESET, S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  typedef enum logic [3:0] {
    I_NONE, I_ALU, I_ADDI, I_LDI, I_LD, I_ST, I_BR,
    I_JR, I_IN, I_MFHI, I_MFLO, I_HALT
  } instr_t;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  state_t     state;
  instr_t     instr;
  instr_t     instr_dec;
  logic [4:0] op_q;
  state_t     finish_state;

  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  // Map the opcode onto an execute sequence; undefined opcodes behave like nop.
  always_comb begin
    // NOTE: default first so every path assigns the variable; otherwise a latch is inferred.
    instr_dec = I_NONE;
    case (IR[31:27])
      5'b00011, 5'b00100, 5'b00101, 5'b00110: instr_dec = I_ALU;
      5'b01100: instr_dec = I_ADDI;
      5'b00001: instr_dec = I_LDI;
      5'b00000: instr_dec = I_LD;
      5'b00010: instr_dec = I_ST;
      5'b10011: instr_dec = I_BR;
      5'b10100: instr_dec = I_JR;
      5'b10110: instr_dec = I_IN;
      5'b11000: instr_dec = I_MFHI;
      5'b11001: instr_dec = I_MFLO;
      5'b11011: instr_dec = I_HALT;
      default:  instr_dec = I_NONE;
    endcase
  end

  // Stop is honoured only on the edge that ends an instruction.
  assign finish_state = Stop ? S_HALT : S_T0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      state <= S_RESET;
      instr <= I_NONE;
      op_q  <= 5'b00000;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_HALT:  state <= S_HALT;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2: begin
          instr <= instr_dec;
          op_q  <= IR[31:27];
          case (instr_dec)
            I_HALT:  state <= S_HALT;
            I_NONE:  state <= finish_state;
            default: state <= S_T3;
          endcase
        end
        S_T3: begin
          if (instr inside {I_JR, I_IN, I_MFHI, I_MFLO}) state <= finish_state;
          else                                           state <= S_T4;
        end
        S_T4: state <= S_T5;
        S_T5: begin
          if (instr inside {I_ALU, I_ADDI, I_LDI}) state <= finish_state;
          else                                     state <= S_T6;
        end
        S_T6: begin
          if (instr == I_BR) state <= finish_state;
          else               state <= S_T7;
        end
        S_T7:    state <= finish_state;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    {PCin, IRin, MARin, MDRin, Yin, Zin, CONin, Rin} = '0;
    {PCout, MDRout, ZLOout, HIout, LOout, INPORTout, Cout, Rout, BAout} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write} = '0;
    Aluop = 5'b00000;
    Run   = (state != S_RESET) && (state != S_HALT);
    case (state)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {ZLOout, PCin, Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        case (instr)
          I_ALU, I_ADDI:       {Grb, Rout, Yin} = '1;
          I_LDI, I_LD, I_ST:   {Grb, BAout, Yin} = '1;
          I_BR:                {Gra, Rout, CONin} = '1;
          I_JR:                {Gra, Rout, PCin} = '1;
          I_IN:                {INPORTout, Gra, Rin} = '1;
          I_MFHI:              {HIout, Gra, Rin} = '1;
          I_MFLO:              {LOout, Gra, Rin} = '1;
          default: ;
        endcase
      end
      S_T4: begin
        case (instr)
          I_ALU: begin
            {Grc, Rout, Zin} = '1;
            Aluop = op_q;
          end
          I_ADDI, I_LDI, I_LD, I_ST: begin
            {Cout, Zin} = '1;
            Aluop = ALU_ADD;
          end
          I_BR:    {PCout, Yin} = '1;
          default: ;
        endcase
      end
      S_T5: begin
        case (instr)
          I_ALU, I_ADDI, I_LDI: {ZLOout, Gra, Rin} = '1;
          I_LD, I_ST:           {ZLOout, MARin} = '1;
          I_BR: begin
            {Cout, Zin} = '1;
            Aluop = ALU_ADD;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (instr)
          I_LD:    {Read, MDRin} = '1;
          I_ST:    {Gra, Rout, MDRin} = '1;
          I_BR:    {ZLOout, PCin} = {CON, CON};
          default: ;
        endcase
      end
      S_T7: begin
        case (instr)
          I_LD:    {MDRout, Gra, Rin} = '1;
          I_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction step-table model queues the expected control word for every cycle.
// A negedge monitor pops and compares these words, and the bench adds directed cases followed by random instruction streams.
module tb_control_unit;

  typedef struct packed {
    logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin, Rin;
    logic PCout, MDRout, ZLOout, HIout, LOout, INPORTout, Cout, Rout, BAout;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [4:0] Aluop;
  } ctrl_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic        Stop = 1'b0;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, CONin, Rin;
  logic PCout, MDRout, ZLOout, HIout, LOout, INPORTout, Cout, Rout, BAout;
  logic Gra, Grb, Grc, IncPC, Read, Write, Run;
  logic [4:0] Aluop;

  int checks = 0;
  int failures = 0;
  ctrl_t sb[$];
  string sb_name[$];
  ctrl_t seq[$];

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON), .Stop(Stop),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .CONin(CONin), .Rin(Rin), .PCout(PCout), .MDRout(MDRout),
    .ZLOout(ZLOout), .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout),
    .Cout(Cout), .Rout(Rout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Run(Run), .Aluop(Aluop)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 200000)", $time);
    $fatal(1, "watchdog");
  end

  function automatic ctrl_t actual();
    return '{PCin, IRin, MARin, MDRin, Yin, Zin, CONin, Rin,
             PCout, MDRout, ZLOout, HIout, LOout, INPORTout, Cout, Rout, BAout,
             Gra, Grb, Grc, IncPC, Read, Write, Run, Aluop};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      ctrl_t e;
      string n;
      e = sb.pop_front();
      n = sb_name.pop_front();
      check(n, 32'(actual()), 32'(e));
    end
  end

  function automatic ctrl_t running();
    ctrl_t t = '0;
    t.Run = 1'b1;
    return t;
  endfunction

  // Expected control word per step of one instruction, straight from the step tables.
  task automatic build_seq(input logic [4:0] op, input logic con);
    ctrl_t t;
    seq.delete();
    t = running(); t.PCout = 1; t.MARin = 1; t.IncPC = 1; t.Zin = 1; seq.push_back(t);
    t = running(); t.ZLOout = 1; t.PCin = 1; t.Read = 1; t.MDRin = 1; seq.push_back(t);
    t = running(); t.MDRout = 1; t.IRin = 1; seq.push_back(t);
    case (op)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        t = running(); t.Grb = 1; t.Rout = 1; t.Yin = 1; seq.push_back(t);
        t = running(); t.Grc = 1; t.Rout = 1; t.Zin = 1; t.Aluop = op; seq.push_back(t);
        t = running(); t.ZLOout = 1; t.Gra = 1; t.Rin = 1; seq.push_back(t);
      end
      5'd12, 5'd1, 5'd0, 5'd2: begin
        t = running(); t.Grb = 1; t.Yin = 1;
        if (op == 5'd12) t.Rout = 1; else t.BAout = 1;
        seq.push_back(t);
        t = running(); t.Cout = 1; t.Zin = 1; t.Aluop = 5'd3; seq.push_back(t);
        t = running(); t.ZLOout = 1;
        if (op == 5'd0 || op == 5'd2) t.MARin = 1; else begin t.Gra = 1; t.Rin = 1; end
        seq.push_back(t);
        if (op == 5'd0) begin
          t = running(); t.Read = 1; t.MDRin = 1; seq.push_back(t);
          t = running(); t.MDRout = 1; t.Gra = 1; t.Rin = 1; seq.push_back(t);
        end else if (op == 5'd2) begin
          t = running(); t.Gra = 1; t.Rout = 1; t.MDRin = 1; seq.push_back(t);
          t = running(); t.Write = 1; seq.push_back(t);
        end
      end
      5'd19: begin
        t = running(); t.Gra = 1; t.Rout = 1; t.CONin = 1; seq.push_back(t);
        t = running(); t.PCout = 1; t.Yin = 1; seq.push_back(t);
        t = running(); t.Cout = 1; t.Zin = 1; t.Aluop = 5'd3; seq.push_back(t);
        t = running(); t.ZLOout = con; t.PCin = con; seq.push_back(t);
      end
      5'd20: begin t = running(); t.Gra = 1; t.Rout = 1; t.PCin = 1; seq.push_back(t); end
      5'd22: begin t = running(); t.INPORTout = 1; t.Gra = 1; t.Rin = 1; seq.push_back(t); end
      5'd24: begin t = running(); t.HIout = 1; t.Gra = 1; t.Rin = 1; seq.push_back(t); end
      5'd25: begin t = running(); t.LOout = 1; t.Gra = 1; t.Rin = 1; seq.push_back(t); end
      default: ;
    endcase
  endtask

  function automatic bit has_execute(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12,
                      5'd19, 5'd20, 5'd22, 5'd24, 5'd25};
  endfunction

  // Called at posedge+1: drive this cycle's inputs, queue its expected word, advance one clock.
  task automatic cycle(input ctrl_t e, input string name, input logic [31:0] ir,
                       input logic con, input logic stop);
    IR = ir; CON = con; Stop = stop;
    sb.push_back(e);
    sb_name.push_back(name);
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle('0, "reset_held", 32'($urandom), 1'b0, 1'b1);
    cycle('0, "reset_held2", 32'($urandom), 1'b0, 1'b0);
    Reset = 1'b0;
    cycle('0, "reset_release", 32'($urandom), 1'b0, 1'b1);
  endtask

  task automatic idle_halt(input int n);
    for (int k = 0; k < n; k++) cycle('0, "halted", 32'($urandom), 1'b1, 1'b0);
  endtask

  // Run one whole instruction; stray_stop pulses Stop in T1, which must be ignored.
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input bit stop_final, input bit stray_stop);
    logic [4:0] op;
    bit halts;
    op = ir[31:27];
    build_seq(op, con);
    for (int i = 0; i < seq.size(); i++) begin
      logic s;
      s = (i == seq.size() - 1) ? logic'(stop_final) : logic'(stray_stop && i == 1);
      cycle(seq[i], $sformatf("op%02h_T%0d", op, i), ir, con, s);
    end
    halts = (op == 5'd27) || stop_final;
    if (halts) begin
      idle_halt(op == 5'd27 ? 10 : 3);
      do_reset();
    end
  endtask

  initial begin
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("reset_async_state", 32'(actual()), 32'(ctrl_t'('0)));
    do_reset();

    run_instr(32'h18A98000, 1'b0, 1'b0, 1'b0);          // add
    run_instr({5'b00000, 27'h123}, 1'b0, 1'b0, 1'b0);   // ld
    run_instr({5'b10011, 27'h0}, 1'b1, 1'b0, 1'b0);     // br taken
    run_instr({5'b10011, 27'h0}, 1'b0, 1'b0, 1'b0);     // br not taken
    run_instr({5'b10100, 27'h0}, 1'b0, 1'b0, 1'b1);     // jr, stray Stop in T1
    run_instr({5'b10100, 27'h0}, 1'b0, 1'b1, 1'b0);     // jr, Stop at T3 -> Halt
    run_instr({5'b11111, 27'h0}, 1'b0, 1'b0, 1'b0);     // undefined
    run_instr({5'b11011, 27'h0}, 1'b0, 1'b0, 1'b0);     // halt, 10 clocks

    // st with Reset asserted in the Write cycle
    build_seq(5'd2, 1'b0);
    for (int i = 0; i < 7; i++) cycle(seq[i], $sformatf("st_T%0d", i), {5'd2, 27'h0}, 1'b0, 1'b0);
    IR = {5'd2, 27'h0}; Stop = 1'b0;
    sb.push_back(seq[7]);
    sb_name.push_back("st_T7_write");
    @(negedge Clock); #2;
    Reset = 1'b1;
    #1;
    check("st_reset_async_write", 32'(Write), 32'(1'b0));
    check("st_reset_async_all", 32'(actual()), 32'(ctrl_t'('0)));
    @(posedge Clock); #1;
    cycle('0, "st_reset_held", 32'h0, 1'b0, 1'b0);
    Reset = 1'b0;
    cycle('0, "st_reset_release", 32'h0, 1'b0, 1'b0);
    run_instr({5'b11010, 27'h0}, 1'b0, 1'b0, 1'b0);     // nop: T0 after restart

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)),
                has_execute(op) && ($urandom_range(0, 5) == 0),
                $urandom_range(0, 3) == 0);
    end

    @(posedge Clock); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
